// File: rtl/fetch_pkg.sv
// Shared Beta fetch definitions: PC-select encodings, instruction constants, buffer entry type.
// Latency: none (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    // PC source select driven by the control unit
    localparam logic [2:0] PC_SEL_INC   = 3'd0;
    localparam logic [2:0] PC_SEL_BR    = 3'd1;
    localparam logic [2:0] PC_SEL_JMP   = 3'd2;
    localparam logic [2:0] PC_SEL_ILLOP = 3'd3;
    localparam logic [2:0] PC_SEL_XADR  = 3'd4;

    // ADD(R31, R31, R31): architectural no-op handed to decode when nothing is fetched
    localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
    // BNE(R31, 0, XP): injected by decode to take an exception
    localparam logic [31:0] INST_BNE_EXCEPT = 32'h77BF_0000;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fbuf_ent_t;

    // Sequential PC step: the supervisor bit never changes by incrementing
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer of {pc_plus4, instr} between imem responses and decode.
// Latency: written entry is visible at head_dat the cycle after push.
// Backpressure: none internally; the fetch credit check guarantees push never hits a full buffer.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  fbuf_ent_t  push_dat,
    input  logic       pop,
    input  logic       flush,
    output fbuf_ent_t  head_dat,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    fbuf_ent_t  ent [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push_ok;
    logic       pop_ok;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = ent[rd_ptr];

    // Pointer/occupancy update; flush discards everything regardless of push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent[0] <= '0;
            ent[1] <= '0;
        end else if (push_ok && !flush) begin
            ent[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/fetch.sv
// Beta instruction fetch: owns the PC, issues imem reads, presents {PC+4, instr} to decode.
// Latency: 2 cycles from request accept to ir with 1-cycle memory; one instruction per cycle steady state.
// Backpressure: stall holds ir/pc; requests stop once outstanding + buffered reaches 2.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] br_addr,
    input  logic [31:0] j_addr,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data
);

    logic [31:0]  fpc;        // next address to request
    logic [31:0]  rsp_pc;     // address of the next response that will be kept
    logic [31:0]  tgt;
    logic [31:0]  ir_q;
    logic [31:0]  pc_q;
    logic         ir_vld_q;
    logic         epoch;
    logic [1:0]   out_cnt;    // requests accepted, response not yet seen (any epoch)
    logic [1:0]   out_after;
    logic [1:0]   tags;       // epoch of each outstanding request, [0] is oldest
    logic [1:0]   stale_cnt;
    logic         stale_head;
    fetch_state_t state;
    fetch_state_t state_nxt;

    logic         redirect;
    logic         fire;
    logic         rsp_pop;
    logic         rsp_keep;
    logic         bypass;
    logic         buf_push;
    logic         buf_pop;
    logic         buf_empty;
    logic         buf_full;
    logic [1:0]   buf_cnt;
    fbuf_ent_t    buf_head;
    fbuf_ent_t    buf_in;

    assign redirect   = (pc_sel != PC_SEL_INC);
    assign fire       = imem_req_valid && imem_req_ready;
    assign rsp_pop    = imem_rsp_valid && (out_cnt != 2'd0);
    assign out_after  = out_cnt - {1'b0, rsp_pop};
    assign stale_head = (tags[0] != epoch);

    // Holding outstanding + buffered at 2 means every response always has a slot
    assign imem_req_valid = rst_n && !redirect
                            && (({1'b0, out_cnt} + {1'b0, buf_cnt}) < 3'd2);
    assign imem_addr      = fpc;

    // Fresh response goes straight to decode when the buffer has nothing older
    assign bypass   = rsp_keep && !stall && buf_empty;
    assign buf_push = rsp_keep && !bypass;
    assign buf_pop  = !redirect && !stall && !buf_empty;
    assign buf_in   = '{pc_plus4: pc_inc(rsp_pc), instr: imem_rsp_data};

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_vld_q;

    // Redirect target; JMP may clear the supervisor bit but never set it
    always_comb begin
        tgt = ILLOP_VEC;
        case (pc_sel)
            PC_SEL_BR:    tgt = {br_addr[31:2], 2'b00};
            PC_SEL_JMP:   tgt = {pc_q[31] & j_addr[31], j_addr[30:2], 2'b00};
            PC_SEL_ILLOP: tgt = ILLOP_VEC;
            PC_SEL_XADR:  tgt = XADR_VEC;
            default:      tgt = ILLOP_VEC;
        endcase
    end

    // Number of outstanding requests belonging to an older epoch
    always_comb begin
        stale_cnt = 2'd0;
        if (out_cnt != 2'd0 && tags[0] != epoch) stale_cnt = stale_cnt + 2'd1;
        if (out_cnt == 2'd2 && tags[1] != epoch) stale_cnt = stale_cnt + 2'd1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // FSM next state and response acceptance; a redirect drops any same-cycle response
    always_comb begin
        state_nxt = state;
        rsp_keep  = 1'b0;
        case (state)
            ST_RUN: begin
                rsp_keep = rsp_pop && !redirect;
            end
            ST_FLUSH: begin
                rsp_keep = rsp_pop && !redirect && !stale_head;
                if ((stale_cnt - {1'b0, rsp_pop && stale_head}) == 2'd0) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
        if (redirect) state_nxt = (out_after != 2'd0) ? ST_FLUSH : ST_RUN;
    end

    // Fetch PC, response PC and epoch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc    <= RESET_VEC;
            rsp_pc <= RESET_VEC;
            epoch  <= 1'b0;
        end else if (redirect) begin
            fpc    <= tgt;
            rsp_pc <= tgt;
            epoch  <= ~epoch;
        end else begin
            if (fire)     fpc    <= pc_inc(fpc);
            if (rsp_keep) rsp_pc <= pc_inc(rsp_pc);
        end
    end

    // Outstanding count and in-order epoch tags; on redirect every survivor is marked old
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= 2'd0;
            tags    <= 2'b00;
        end else if (redirect) begin
            out_cnt <= out_after;
            tags    <= {epoch, epoch};
        end else begin
            case ({fire, rsp_pop})
                2'b10: begin
                    if (out_cnt == 2'd0) tags[0] <= epoch;
                    else                 tags[1] <= epoch;
                    out_cnt <= out_cnt + 2'd1;
                end
                2'b01: begin
                    tags[0] <= tags[1];
                    out_cnt <= out_cnt - 2'd1;
                end
                2'b11: begin
                    if (out_cnt == 2'd1) begin
                        tags[0] <= epoch;
                    end else begin
                        tags[0] <= tags[1];
                        tags[1] <= epoch;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decode-facing register: cleared on redirect, held on stall, else head/bypass/NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q     <= INST_NOP;
            pc_q     <= RESET_VEC;
            ir_vld_q <= 1'b0;
        end else if (redirect) begin
            ir_q     <= INST_NOP;
            ir_vld_q <= 1'b0;
        end else if (!stall) begin
            if (!buf_empty) begin
                ir_q     <= buf_head.instr;
                pc_q     <= buf_head.pc_plus4;
                ir_vld_q <= 1'b1;
            end else if (bypass) begin
                ir_q     <= imem_rsp_data;
                pc_q     <= pc_inc(rsp_pc);
                ir_vld_q <= 1'b1;
            end else begin
                ir_q     <= INST_NOP;
                ir_vld_q <= 1'b0;
            end
        end
    end

    fetch_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (buf_push),
        .push_dat (buf_in),
        .pop      (buf_pop),
        .flush    (redirect),
        .head_dat (buf_head),
        .count    (buf_cnt),
        .full     (buf_full),
        .empty    (buf_empty)
    );

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  pc_sel;
    logic [31:0] br_addr;
    logic [31:0] j_addr;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_sel         (pc_sel),
        .br_addr        (br_addr),
        .j_addr         (j_addr),
        .stall          (stall),
        .pc             (pc),
        .ir             (ir),
        .ir_valid       (ir_valid),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data)
    );

    typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    exp_t        sb[$];
    req_t        pend[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          lat    = 1;
    logic        rdy_cfg = 1'b1;
    logic [31:0] efpc   = 32'h8000_0000;

    logic [31:0] s_pc, s_ir, s_addr;
    logic        s_vld, s_req, s_rsp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h7BFF_0000;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] inc4(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

    // One clock cycle: drive inputs and memory response, sample, update scoreboard/memory model
    task automatic tick(input logic [2:0] sel, input logic [31:0] ba,
                        input logic [31:0] ja, input logic stl);
        exp_t        e;
        req_t        r;
        logic [31:0] t;
        @(negedge clk);
        pc_sel = sel; br_addr = ba; j_addr = ja; stall = stl;
        imem_req_ready = rdy_cfg;
        s_rsp = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
            s_rsp = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        s_pc = pc; s_ir = ir; s_vld = ir_valid; s_req = imem_req_valid; s_addr = imem_addr;
        if (!stl) begin
            if (ir_valid) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("pc", pc, e.pc);
                    chk("ir", ir, e.ir);
                end
            end else begin
                chk("nop_ir", ir, INST_NOP);
            end
        end
        if (sel != PC_SEL_INC) begin
            chk("no_req_on_redirect", imem_req_valid, 0);
            sb.delete();
            case (sel)
                PC_SEL_BR:    t = {ba[31:2], 2'b00};
                PC_SEL_JMP:   t = {pc[31] & ja[31], ja[30:2], 2'b00};
                PC_SEL_ILLOP: t = 32'h8000_0004;
                default:      t = 32'h8000_0008;
            endcase
            efpc = t;
        end else if (imem_req_valid && imem_req_ready) begin
            chk("imem_addr", imem_addr, efpc);
            e.pc = inc4(efpc); e.ir = mem_word(efpc);
            sb.push_back(e);
            r.addr = efpc; r.due = cyc + lat;
            pend.push_back(r);
            efpc = inc4(efpc);
        end
        chk("inflight_le2", pend.size() <= 2, 1);
        cyc++;
    endtask

    task automatic run_until_valid(input int max);
        logic ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
            if (s_vld) ok = 1'b1;
        end
        chk("wait_valid", ok, 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_ir", ir, INST_NOP);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
    endtask

    initial begin
        int          first;
        int          nv;
        logic [31:0] first_ir, first_pc, h_pc, h_ir, rnd;
        logic [2:0]  sel;
        int          r;
        rst_n = 1'b0; pc_sel = PC_SEL_INC; br_addr = '0; j_addr = '0; stall = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #2 rst_n = 1'b1;

        // reset release, first fetch latency, zero-bubble stream
        first = -1; nv = 0; first_ir = '0; first_pc = '0;
        for (int i = 0; i < 12; i++) begin
            tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
            if (i == 0) begin
                chk("first_req_vld", s_req, 1);
                chk("first_req_addr", s_addr, 32'h8000_0000);
            end
            if (s_vld && first < 0) begin first = i; first_ir = s_ir; first_pc = s_pc; end
            if (i >= 2 && s_vld) nv++;
        end
        chk("first_latency", first, 2);
        chk("first_ir", first_ir, 32'h7BFF_0000);
        chk("first_pc", first_pc, 32'h8000_0004);
        chk("zero_bubble", nv, 10);

        // stall for 3 cycles
        tick(PC_SEL_INC, 32'h0, 32'h0, 1'b1);
        h_pc = s_pc; h_ir = s_ir;
        chk("stall1_vld", s_vld, 1);
        for (int i = 0; i < 2; i++) begin
            tick(PC_SEL_INC, 32'h0, 32'h0, 1'b1);
            chk("stall_pc_hold", s_pc, h_pc);
            chk("stall_ir_hold", s_ir, h_ir);
            chk("stall_req_drop", s_req, 0);
        end
        repeat (6) tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);

        // branch with two fetches outstanding (2-cycle memory)
        lat = 2;
        for (int i = 0; i < 10 && pend.size() != 2; i++) tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
        chk("two_outstanding", pend.size(), 2);
        tick(PC_SEL_BR, 32'h8000_0100, 32'h0, 1'b0);
        tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
        chk("br_req_vld", s_req, 1);
        chk("br_req_addr", s_addr, 32'h8000_0100);
        run_until_valid(10);
        chk("br_first_pc", s_pc, 32'h8000_0104);
        chk("br_first_ir", s_ir, mem_word(32'h8000_0100));
        lat = 1;

        // user-mode jump cannot set the supervisor bit
        tick(PC_SEL_BR, 32'h0000_0100, 32'h0, 1'b0);
        run_until_valid(10);
        chk("user_pc", s_pc, 32'h0000_0104);
        tick(PC_SEL_JMP, 32'h0, 32'h8000_0200, 1'b0);
        tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
        chk("jmp_req_addr", s_addr, 32'h0000_0200);
        run_until_valid(10);
        chk("jmp_first_pc", s_pc, 32'h0000_0204);

        // exception together with stall and a response
        repeat (4) tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
        tick(PC_SEL_XADR, 32'h0, 32'h0, 1'b1);
        chk("xadr_rsp_same_cycle", s_rsp, 1);
        tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
        chk("xadr_req_vld", s_req, 1);
        chk("xadr_req_addr", s_addr, 32'h8000_0008);
        chk("xadr_ir_nop", s_ir, INST_NOP);
        chk("xadr_ir_vld", s_vld, 0);
        run_until_valid(10);
        chk("xadr_first_pc", s_pc, 32'h8000_000C);
        tick(PC_SEL_ILLOP, 32'h0, 32'h0, 1'b0);
        tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
        chk("illop_req_addr", s_addr, 32'h8000_0004);

        // random traffic: stalls, memory latency, ready gaps, redirects
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            rdy_cfg = ($urandom_range(0, 4) != 0);
            r = $urandom_range(0, 19);
            sel = (r == 0) ? PC_SEL_BR : (r == 1) ? PC_SEL_JMP :
                  (r == 2) ? PC_SEL_XADR : (r == 3) ? PC_SEL_ILLOP : PC_SEL_INC;
            rnd = $urandom;
            tick(sel, {rnd[31:2], 2'b00}, {rnd[15:0], rnd[31:16]}, $urandom_range(0, 3) == 0);
        end

        // drain: no new requests, everything in flight must reach decode
        rdy_cfg = 1'b0;
        for (int i = 0; i < 20 && (sb.size() != 0 || pend.size() != 0); i++)
            tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
        chk("drain", sb.size(), 0);
        rdy_cfg = 1'b1; lat = 1;

        // reset in mid-operation
        repeat (5) tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        check_reset_vals();
        pend.delete(); sb.delete(); efpc = 32'h8000_0000;
        @(posedge clk); #2 rst_n = 1'b1;
        tick(PC_SEL_INC, 32'h0, 32'h0, 1'b0);
        chk("rerst_req_addr", s_addr, 32'h8000_0000);
        run_until_valid(10);
        chk("rerst_first_ir", s_ir, 32'h7BFF_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
